// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field bounds, opcode constants,
// the fetch-queue entry payload and a HLT detector.
package mips_pkg;

    localparam int unsigned MIPS_ADDR_W = 10;
    localparam int unsigned OPC_MSB     = 31;
    localparam int unsigned OPC_LSB     = 26;

    localparam logic [5:0] OPC_ADD   = 6'b000000;
    localparam logic [5:0] OPC_SUB   = 6'b000001;
    localparam logic [5:0] OPC_AND   = 6'b000010;
    localparam logic [5:0] OPC_OR    = 6'b000011;
    localparam logic [5:0] OPC_SLT   = 6'b000100;
    localparam logic [5:0] OPC_MUL   = 6'b000101;
    localparam logic [5:0] OPC_LW    = 6'b001000;
    localparam logic [5:0] OPC_SW    = 6'b001001;
    localparam logic [5:0] OPC_ADDI  = 6'b001010;
    localparam logic [5:0] OPC_SUBI  = 6'b001011;
    localparam logic [5:0] OPC_SLTI  = 6'b001100;
    localparam logic [5:0] OPC_BNEQZ = 6'b001101;
    localparam logic [5:0] OPC_BEQZ  = 6'b001110;
    localparam logic [5:0] OPC_HLT   = 6'b111111;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[OPC_MSB:OPC_LSB] == OPC_HLT;
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch queue: shift-style FIFO whose entry 0 is the head register,
// with push, pop and single-cycle flush.
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [31:0]             i_ir,
    input  logic [31:0]             i_npc,
    output logic [31:0]             o_ir,
    output logic [31:0]             o_npc,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_wr_idx;

    // A simultaneous pop shifts everything down, so the free slot moves down by one.
    assign w_wr_idx = i_pop ? AW'(r_count - CW'(1)) : AW'(r_count);

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            if (i_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (i_push) begin
                r_mem[w_wr_idx] <= '{ir: i_ir, npc: i_npc};
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_ir    = r_mem[0].ir;
    assign o_npc   = r_mem[0].npc;
    assign o_count = r_count;

endmodule

// File: rtl/mips_fetch_queue.sv
// MIPS instruction-fetch front end: PC, memory issue, prefetch queue, redirect/HLT/halt.
// Optional MIPS_FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = MIPS_ADDR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_in,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ir,
    output logic [31:0]       id_npc
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_flushed
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_iss_addr;
    logic              r_inflight;
    logic              r_stop;
    logic              r_halted;

    logic [CW-1:0]     w_count;
    logic              w_req;
    logic              w_br;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_npc_in;

    // Issue only while queue plus outstanding response still fits.
    assign w_br     = br_taken && !r_halted;
    assign w_req    = !rst && !r_halted && !r_stop && !br_taken
                      && ((w_count + CW'(r_inflight)) < CW'(DEPTH));
    assign w_push   = r_inflight && !r_stop && !w_br && !r_halted;
    assign id_valid = (w_count != '0) && !r_halted;
    assign w_pop    = id_valid && id_ready && !w_br;
    assign w_npc_in = 32'(r_iss_addr) + 32'd1;

    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    mips_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1    (clk1),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_br),
        .i_ir    (imem_rdata),
        .i_npc   (w_npc_in),
        .o_ir    (id_ir),
        .o_npc   (id_npc),
        .o_count (w_count)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_pc       <= ADDR_W'(RESET_PC);
            r_iss_addr <= '0;
            r_inflight <= 1'b0;
            r_stop     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (halt_in) begin
                r_halted <= 1'b1;
            end
            r_inflight <= w_req;
            if (w_req) begin
                r_iss_addr <= r_pc;
                r_pc       <= r_pc + ADDR_W'(1);
            end
            // Redirect never coincides with an issue, so it owns the PC this cycle.
            if (w_br) begin
                r_pc   <= br_target;
                r_stop <= 1'b0;
            end else if (w_push && is_hlt(imem_rdata)) begin
                r_stop <= 1'b1;
            end
        end
    end

`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_flushed;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_stat_fetched <= '0;
            r_stat_flushed <= '0;
        end else begin
            if (w_push) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (w_br) begin
                r_stat_flushed <= r_stat_flushed + 32'(w_count) + 32'(r_inflight);
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed scenarios plus random traffic against a
// queue-based reference model; honours MIPS_FETCH_STATS_EN when defined.
module tb_mips_fetch_queue;

    localparam int DEPTH = 4;
    localparam int MEMW  = 1024;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [9:0]  br_target;
    logic        halt_in;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    always #5 clk1 = ~clk1;

    mips_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (10),
        .RESET_PC (0)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt_in    (halt_in),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_ir      (id_ir),
        .id_npc     (id_npc)
`ifdef MIPS_FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed)
`endif
    );

    // Synchronous instruction memory: data one cycle after the request.
    logic [31:0] mem [MEMW];
    always @(posedge clk1) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural view of the front end.
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;

    ent_t        m_q[$];
    int          m_pc;
    int          m_iaddr;
    bit          m_inf;
    bit          m_stop;
    bit          m_halted;
    bit          m_known;
    int unsigned m_fetched;
    int unsigned m_flushed;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3f) w[31] = 1'b0;
        return w;
    endfunction

    task automatic step(input bit b, input int tgt, input bit rdy, input bit h, input bit r);
        bit   exp_req;
        bit   exp_val;
        bit   br_acc;
        bit   push;
        bit   pop;
        ent_t e;
        @(negedge clk1);
        rst       = r;
        br_taken  = b;
        br_target = 10'(tgt);
        id_ready  = rdy;
        halt_in   = h;
        #1;
        exp_req = !r && !m_halted && !m_stop && !b && ((m_q.size() + int'(m_inf)) < DEPTH);
        exp_val = (m_q.size() > 0) && !m_halted;
        if (m_known) begin
            check("imem_req", 64'(imem_req), 64'(exp_req));
            check("imem_addr", 64'(imem_addr), 64'(m_pc));
            check("id_valid", 64'(id_valid), 64'(exp_val));
            if (exp_val) begin
                check("id_ir", 64'(id_ir), 64'(m_q[0].ir));
                check("id_npc", 64'(id_npc), 64'(m_q[0].npc));
            end
`ifdef MIPS_FETCH_STATS_EN
            check("stat_fetched", 64'(stat_fetched), 64'(m_fetched));
            check("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
`endif
        end
        if (r) begin
            m_q.delete();
            m_pc      = 0;
            m_iaddr   = 0;
            m_inf     = 0;
            m_stop    = 0;
            m_halted  = 0;
            m_fetched = 0;
            m_flushed = 0;
            m_known   = 1;
            return;
        end
        br_acc = b && !m_halted;
        push   = m_inf && !m_stop && !br_acc && !m_halted;
        pop    = exp_val && rdy && !br_acc;
        if (br_acc) begin
            m_flushed += m_q.size() + int'(m_inf);
            m_q.delete();
            m_pc   = tgt;
            m_stop = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.ir  = mem[m_iaddr];
                e.npc = 32'(m_iaddr + 1);
                m_q.push_back(e);
                m_fetched++;
                if (e.ir[31:26] == 6'h3f) m_stop = 1;
            end
        end
        if (h) m_halted = 1;
        m_inf = exp_req;
        if (exp_req) begin
            m_iaddr = m_pc;
            m_pc    = (m_pc + 1) % MEMW;
        end
    endtask

    initial begin
        bit b;
        bit rdy;
        bit h;
        bit r;
        int tgt;

        rst = 1'b1; br_taken = 1'b0; br_target = '0; halt_in = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < MEMW; i++) mem[i] = rand_word();

        // Reset state and in-order streaming
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        #2;
        check("reset_id_ir", 64'(id_ir), 64'h0);
        check("reset_id_npc", 64'(id_npc), 64'h0);
        check("reset_id_valid", 64'(id_valid), 64'h0);
        repeat (12) step(0, 0, 1, 0, 0);

        // Back-pressure fill then drain
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0);

        // Redirect with three queued and one in flight
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && !(m_q.size() == 3 && m_inf); i++) step(0, 0, 0, 0, 0);
        check("fill_wait", 64'(m_q.size()), 64'd3);
        step(1, 32'h20, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0);

        // HLT at word 5, then restart from 0
        mem[5] = {6'h3f, 26'(rand_word())};
        step(1, 0, 1, 0, 0);
        repeat (20) step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (12) step(0, 0, 1, 0, 0);
        mem[5] = rand_word();

        // PC wrap at the top of memory
        step(1, 1023, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0);

        // Halt with two queued; redirect ignored; only reset recovers
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && m_q.size() != 2; i++) step(0, 0, 0, 0, 0);
        check("fill2_wait", 64'(m_q.size()), 64'd2);
        step(0, 0, 1, 1, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        step(1, 40, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        repeat (6) step(0, 0, 1, 0, 0);

        // Random traffic with scattered HLTs
        for (int i = 0; i < 12; i++) mem[$urandom_range(MEMW - 1, 0)] = {6'h3f, 26'($urandom)};
        repeat (4000) begin
            b   = ($urandom % 12) == 0;
            tgt = int'($urandom % MEMW);
            rdy = ($urandom % 4) != 0;
            h   = ($urandom % 400) == 0;
            r   = m_halted ? (($urandom % 10) == 0) : (($urandom % 1000) == 0);
            step(b, tgt, rdy, h, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_fetch_queue.md
Name: mips_fetch_queue

Overview:
Instruction-fetch front end feeding the MIPS decode stage. It owns the PC, issues word reads to the synchronous instruction memory, and buffers the returned instructions with their next-PC in a small prefetch queue. It presents them to decode through a valid/ready handshake. It also handles branch redirects from execute, self-stops on a fetched HLT opcode, and freezes on the write-back halt.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, >=2)
ADDR_W, 10, instruction word-address width (1024-word memory)
RESET_PC, 0, PC value after reset

Ports:
clk1  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  read request this cycle (combinational from state)
imem_addr  out  ADDR_W  word address of request (= pc)
imem_rdata  in  32  instruction; valid exactly one cycle after imem_req
br_taken  in  1  redirect pulse from execute
br_target  in  ADDR_W  redirect word address
halt_in  in  1  halt from write-back; sticky once seen
id_valid  out  1  queue head valid
id_ready  in  1  decode accepts head
id_ir  out  32  head instruction
id_npc  out  32  head next-PC (fetch address + 1, zero-extended)

Behaviour:
- Reset: pc=RESET_PC, queue empty, in-flight flag=0, stop=0, halted=0. Outputs: id_valid=0, imem_req=0, id_ir=0, id_npc=0.
- Issue rule: imem_req = !halted && !stop && !br_taken && (count + inflight) < DEPTH. Each issue sets pc <= pc+1, modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. inflight <= imem_req.
- Response: the cycle after an issue, if inflight and not discarded, push {imem_rdata, issued_addr+1}. The issued address is registered alongside inflight. Issue-space accounting guarantees a push never overflows.
- Latency: request at cycle N; entry captured at end of N+1; id_valid high in N+2.
- Throughput: 1 instruction/cycle in steady state when id_ready=1.
- Output: id_valid = !empty. id_ir and id_npc come from the head register. Pop on id_valid && id_ready.
- Simultaneous push and pop keeps count unchanged. Pop when empty is impossible (id_valid=0). id_ir and id_npc are held while id_valid && !id_ready.
- Redirect (br_taken=1 in cycle T): the queue is flushed, any in-flight response is discarded, and any pop that cycle is ignored. Also pc <= br_target, stop <= 0, and no request is issued in T.
- Redirect timing: request for br_target in T+1; its entry is valid in T+3.
- HLT self-stop: when a pushed instruction has bits[31:26]=6'b111111, stop <= 1 and further issue ceases. A response already in flight when stop sets is discarded. The HLT entry itself is delivered normally. Only a redirect or rst clears stop.
- Halt: halt_in=1 sets halted (sticky until rst). While halted: no issue, no push, no pop, id_valid forced 0, queue contents frozen. br_taken is ignored once halted.
- Precedence: rst > halted > br_taken > push/pop.
- rst mid-operation discards the queue and any in-flight response. The first request goes to RESET_PC in the cycle after rst deasserts.

Optional Feature:
MIPS_FETCH_STATS_EN
- Defined: adds outputs stat_fetched (32) and stat_flushed (32), both reset to 0 and wrapping.
- stat_fetched increments by 1 per push.
- stat_flushed increments by count plus the discarded in-flight response (0/1) on each accepted redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: opcode constants (HLT=6'b111111, BEQZ, BNEQZ, etc.), OPC_MSB/OPC_LSB field bounds, default ADDR_W.
- Sub-module mips_fetch_fifo: synchronous FIFO with DEPTH entries, push/pop/flush, count, registered head output.
- The top-level block holds the PC, in-flight/discard tracking, stop/halt state and issue logic.

Test Plan:
1. Reset with RESET_PC=0, memory words 0..7 non-HLT, id_ready=1. Expect imem_addr 0,1,2… on consecutive cycles, id_valid from cycle 2, and id_npc 1,2,3… with no gaps.
2. Hold id_ready=0. Expect exactly DEPTH=4 entries to fill, imem_req=0 thereafter, and the head stable. Then release id_ready: expect 4 back-to-back pops with no loss or duplication.
3. Pulse br_taken with br_target=0x020 while the queue holds 3 entries and 1 is in flight. Expect the queue empty next cycle, imem_addr=0x020 at T+1, id_ir=Mem[0x20] valid at T+3, and stat_fetched unaffected by the flush. With MIPS_FETCH_STATS_EN, stat_flushed increments by 4.
4. Place HLT at address 5. Expect entries 0..5 delivered, the word-6 response discarded, imem_req=0 thereafter, and id_valid=0 after the HLT pops. Then br_taken with target 0 restarts fetch.
5. Assert halt_in with 2 entries queued and id_ready=1. Expect id_valid=0 and imem_req=0 from the next cycle. A later br_taken has no effect; only rst restores fetch from RESET_PC.
6. Set pc=1023 via a redirect with ADDR_W=10. Expect imem_addr sequence 1023, 0, 1 and id_npc for the 1023 entry = 1024.
